// File: rtl/lfsr_checker.sv
// ============================================================================
// Module   : lfsr_checker
// Brief    : Self-synchronising receive checker for the 4-bit LFSR pattern.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lfsr_checker #(
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_i,
  input  logic [3:0]       data_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [3:0]       expected_o
);

  localparam int c_RUN_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
  localparam int c_RUN_W   = $clog2(c_RUN_MAX + 1);

  localparam logic [c_RUN_W-1:0] c_RUN_ONE     = c_RUN_W'(1);
  localparam logic [c_RUN_W-1:0] c_LOCK_CNT    = c_RUN_W'(LOCK_COUNT);
  localparam logic [c_RUN_W-1:0] c_UNLOCK_CNT  = c_RUN_W'(UNLOCK_COUNT);
  localparam logic [CNT_W-1:0]   c_CNT_ONE     = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  state_t             r_state;
  logic [3:0]         r_exp;
  logic [c_RUN_W-1:0] r_good;
  logic [c_RUN_W-1:0] r_bad;
  logic               r_err;
  logic [CNT_W-1:0]   r_cnt;

  state_t             w_state_nxt;
  logic [3:0]         w_exp_nxt;
  logic [c_RUN_W-1:0] w_good_nxt;
  logic [c_RUN_W-1:0] w_bad_nxt;
  logic               w_err_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  logic [c_RUN_W-1:0] w_good_inc;
  logic [c_RUN_W-1:0] w_bad_inc;
  logic               w_cnt_sat;

  function automatic logic [3:0] f_nxt(input logic [3:0] x);
    return {x[2:0], x[1] ^ x[3]};
  endfunction

  assign w_good_inc = r_good + c_RUN_ONE;
  assign w_bad_inc  = r_bad + c_RUN_ONE;
  assign w_cnt_sat  = &r_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_exp_nxt   = r_exp;
    w_good_nxt  = r_good;
    w_bad_nxt   = r_bad;
    w_err_nxt   = 1'b0;
    w_cnt_nxt   = r_cnt;

    if (valid_i) begin
      if (r_state == ST_UNLOCKED) begin
        if (data_i == 4'h0) begin
          w_good_nxt = '0;
          w_exp_nxt  = 4'h0;
        end else if ((r_good == '0) || (data_i != r_exp)) begin
          // Any non-zero word that breaks the run becomes the new seed.
          w_exp_nxt  = f_nxt(data_i);
          w_good_nxt = c_RUN_ONE;
        end else begin
          w_exp_nxt  = f_nxt(data_i);
          w_good_nxt = w_good_inc;
          if (w_good_inc == c_LOCK_CNT) begin
            w_state_nxt = ST_LOCKED;
            w_bad_nxt   = '0;
          end
        end
      end else begin
        // Prediction free-runs so a corrupted word cannot derail the sequence.
        w_exp_nxt = f_nxt(r_exp);
        if (data_i == r_exp) begin
          w_bad_nxt = '0;
        end else begin
          w_err_nxt = 1'b1;
          if (!w_cnt_sat) begin
            w_cnt_nxt = r_cnt + c_CNT_ONE;
          end
          w_bad_nxt = w_bad_inc;
          if (w_bad_inc == c_UNLOCK_CNT) begin
            w_state_nxt = ST_UNLOCKED;
            w_good_nxt  = '0;
            w_exp_nxt   = 4'h0;
          end
        end
      end
    end

    if (clear_i) begin
      w_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_UNLOCKED;
      r_exp   <= 4'h0;
      r_good  <= '0;
      r_bad   <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_exp   <= w_exp_nxt;
      r_good  <= w_good_nxt;
      r_bad   <= w_bad_nxt;
      r_err   <= w_err_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign locked_o   = (r_state == ST_LOCKED);
  assign err_o      = r_err;
  assign err_cnt_o  = r_cnt;
  assign expected_o = r_exp;

endmodule

`default_nettype wire

// File: tb/tb_lfsr_checker.sv
// ============================================================================
// Module   : tb_lfsr_checker
// Brief    : Directed and random checks of lfsr_checker against a sequence model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_i;
  logic [3:0]  data_i;
  logic        clear_i;
  logic        locked_o;
  logic        err_o;
  logic [15:0] err_cnt_o;
  logic [3:0]  expected_o;
  logic        s_locked;
  logic        s_err;
  logic [1:0]  s_cnt;
  logic [3:0]  s_exp;

  always #5 clk = ~clk;

  lfsr_checker #(.LOCK_COUNT(4), .UNLOCK_COUNT(3), .CNT_W(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .data_i(data_i),
    .clear_i(clear_i), .locked_o(locked_o), .err_o(err_o),
    .err_cnt_o(err_cnt_o), .expected_o(expected_o)
  );

  lfsr_checker #(.LOCK_COUNT(4), .UNLOCK_COUNT(3), .CNT_W(2)) u_dut_small (
    .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .data_i(data_i),
    .clear_i(clear_i), .locked_o(s_locked), .err_o(s_err),
    .err_cnt_o(s_cnt), .expected_o(s_exp)
  );

  typedef struct {
    bit locked;
    int exp;
    int good;
    int bad;
    bit err;
    int cnt;
  } mst_t;

  mst_t m;
  mst_t ms;
  int   n_checks = 0;
  int   n_errors = 0;

  // Generator law written arithmetically: shift left in 4 bits, feed back x1 xor x3.
  function automatic int nxt(int x);
    return ((x * 2) % 16) + (((x / 2) ^ (x / 8)) & 1);
  endfunction

  function automatic mst_t mreset();
    mst_t r;
    r.locked = 0; r.exp = 0; r.good = 0; r.bad = 0; r.err = 0; r.cnt = 0;
    return r;
  endfunction

  function automatic mst_t mstep(mst_t s, bit v, int d, bit clr, int cmax);
    mst_t n = s;
    n.err = 0;
    if (v) begin
      if (!s.locked) begin
        if (d == 0) begin
          n.good = 0; n.exp = 0;
        end else if (s.good == 0 || d != s.exp) begin
          n.exp = nxt(d); n.good = 1;
        end else begin
          n.exp = nxt(d); n.good = s.good + 1;
          if (n.good == 4) begin n.locked = 1; n.bad = 0; end
        end
      end else begin
        n.exp = nxt(s.exp);
        if (d == s.exp) n.bad = 0;
        else begin
          n.err = 1;
          if (s.cnt < cmax) n.cnt = s.cnt + 1;
          n.bad = s.bad + 1;
          if (n.bad == 3) begin n.locked = 0; n.good = 0; n.exp = 0; end
        end
      end
    end
    if (clr) n.cnt = 0;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("locked", {31'b0, locked_o}, {31'b0, m.locked});
    chk("err", {31'b0, err_o}, {31'b0, m.err});
    chk("cnt", {16'b0, err_cnt_o}, m.cnt);
    chk("expected", {28'b0, expected_o}, m.exp);
    chk("s_locked", {31'b0, s_locked}, {31'b0, ms.locked});
    chk("s_err", {31'b0, s_err}, {31'b0, ms.err});
    chk("s_cnt", {30'b0, s_cnt}, ms.cnt);
    chk("s_expected", {28'b0, s_exp}, ms.exp);
  endtask

  task automatic step(input bit v, input int d, input bit c);
    int dd;
    dd = d & 15;
    valid_i = v;
    data_i  = dd[3:0];
    clear_i = c;
    @(posedge clk);
    m  = mstep(m, v, dd, c, 65535);
    ms = mstep(ms, v, dd, c, 3);
    #1;
    check_all();
  endtask

  task automatic feed_until_locked(input string tag);
    int guard = 0;
    while (!m.locked && guard < 20) begin
      step(1, (m.exp == 0) ? 1 : m.exp, 0);
      guard++;
    end
    chk(tag, {31'b0, locked_o}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int guard;
    int words;
    reset_n = 1'b0; valid_i = 1'b0; data_i = 4'h0; clear_i = 1'b0;
    m = mreset(); ms = mreset();
    #12;
    check_all();
    @(negedge clk);
    reset_n = 1'b1;

    // Lock acquisition
    step(1, 1, 0); step(1, 2, 0); step(1, 5, 0);
    chk("no_early_lock", {31'b0, locked_o}, 32'd0);
    step(1, 'hA, 0);
    chk("lock_acq", {31'b0, locked_o}, 32'd1);
    chk("lock_expected", {28'b0, expected_o}, 32'h4);

    // Clean run with random valid gaps
    sent = 0; guard = 0;
    while (sent < 12 && guard < 200) begin
      bit v;
      v = 1'($urandom_range(1, 0));
      step(v, v ? m.exp : int'($urandom_range(15, 0)), 0);
      if (v) sent++;
      guard++;
    end
    chk("clean_cnt", {16'b0, err_cnt_o}, 32'd0);
    chk("clean_locked", {31'b0, locked_o}, 32'd1);

    // Single error in place of 4
    guard = 0;
    while (m.exp != 4 && guard < 8) begin step(1, m.exp, 0); guard++; end
    chk("align_to_4", {28'b0, expected_o}, 32'h4);
    step(1, 'hF, 0);
    chk("single_err_pulse", {31'b0, err_o}, 32'd1);
    step(1, 8, 0);
    chk("single_err_once", {31'b0, err_o}, 32'd0);
    step(1, 1, 0);
    chk("single_err_cnt", {16'b0, err_cnt_o}, 32'd1);
    chk("single_err_locked", {31'b0, locked_o}, 32'd1);

    // Loss and relock
    step(0, 0, 1);
    step(1, 0, 0); step(1, 0, 0);
    chk("loss_still_locked", {31'b0, locked_o}, 32'd1);
    step(1, 0, 0);
    chk("loss_unlocked", {31'b0, locked_o}, 32'd0);
    chk("loss_cnt", {16'b0, err_cnt_o}, 32'd3);
    step(1, 5, 0); step(1, 'hA, 0); step(1, 4, 0); step(1, 8, 0);
    chk("relock", {31'b0, locked_o}, 32'd1);
    chk("relock_cnt", {16'b0, err_cnt_o}, 32'd3);

    // Seed edge cases
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    chk("zeros_unlocked", {31'b0, locked_o}, 32'd0);
    chk("zeros_unseeded", {28'b0, expected_o}, 32'd0);
    step(1, 1, 0); step(1, 2, 0); step(1, 7, 0); step(1, 'hE, 0); step(1, 'hC, 0);
    chk("reseed_no_lock", {31'b0, locked_o}, 32'd0);
    chk("reseed_expected", {28'b0, expected_o}, 32'h9);
    words = 0;
    while (!m.locked && words < 6) begin step(1, m.exp, 0); words++; end
    chk("reseed_words_to_lock", words, 32'd2);
    chk("reseed_locked", {31'b0, locked_o}, 32'd1);

    // Saturation of the narrow counter
    step(0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, m.exp ^ 5, 0);
      step(1, m.exp, 0);
      step(1, m.exp, 0);
    end
    chk("sat_small_cnt", {30'b0, s_cnt}, 32'd3);
    chk("sat_wide_cnt", {16'b0, err_cnt_o}, 32'd5);

    // Clear together with an error
    step(1, m.exp ^ 3, 1);
    chk("clear_cnt", {16'b0, err_cnt_o}, 32'd0);
    chk("clear_err_pulse", {31'b0, err_o}, 32'd1);
    chk("clear_locked", {31'b0, locked_o}, 32'd1);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      bit v;
      bit c;
      int d;
      v = ($urandom_range(3, 0) != 0);
      c = ($urandom_range(31, 0) == 0);
      if ($urandom_range(7, 0) == 0) d = int'($urandom_range(15, 0));
      else if (m.exp == 0) d = int'($urandom_range(15, 1));
      else d = m.exp;
      step(v, d, c);
    end

    // Asynchronous reset while locked
    feed_until_locked("pre_reset_locked");
    step(1, m.exp ^ 1, 0);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    m = mreset(); ms = mreset();
    chk("async_rst_locked", {31'b0, locked_o}, 32'd0);
    chk("async_rst_cnt", {16'b0, err_cnt_o}, 32'd0);
    chk("async_rst_err", {31'b0, err_o}, 32'd0);
    chk("async_rst_expected", {28'b0, expected_o}, 32'd0);
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset_n = 1'b1;
    step(1, 1, 0); step(1, 2, 0); step(1, 5, 0); step(1, 'hA, 0);
    chk("post_reset_lock", {31'b0, locked_o}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Receive-side checker for the 4-bit LFSR pattern generator. It consumes the generator's parallel 4-bit words, self-synchronises to the sequence, then counts word errors.
- Sits at the far end of a link or datapath under test. Link BIST uses it to qualify the path that the generator drives.
- Generator law, fixed: nxt(x) = {x[2:0], x[1]^x[3]}.
- Sequence from seed 0x1: 1,2,5,A,4,8,1,… (period 6). The all-zero word is the lock-up state and is never valid pattern data.

Parameters:
- LOCK_COUNT, 4: consecutive consistent words, including the seed word, required to declare lock; legal range ≥2.
- UNLOCK_COUNT, 3: consecutive mismatching words while locked that drop lock; legal range ≥1.
- CNT_W, 16: width of the error counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- valid_i  in  1  data_i is a pattern word this cycle.
- data_i  in  4  received pattern word.
- clear_i  in  1  synchronous clear of err_cnt_o.
- locked_o  out  1  checker is synchronised to the sequence.
- err_o  out  1  one-cycle pulse per mismatching word while locked.
- err_cnt_o  out  CNT_W  saturating count of mismatching words while locked.
- expected_o  out  4  next predicted word; 0 when unseeded.

Behaviour:
- Reset, asynchronous on reset_n low: state UNLOCKED, exp=0, good_run=0, bad_run=0, locked_o=0, err_o=0, err_cnt_o=0. All outputs are registered.
- valid_i low: no state change; err_o=0 next cycle.
- UNLOCKED, valid_i high:
  - data_i==0: good_run←0, exp←0 (unseeded).
  - good_run==0 and data_i≠0: this is the seed word; exp←nxt(data_i), good_run←1.
  - data_i==exp: exp←nxt(data_i), good_run←good_run+1. If good_run+1==LOCK_COUNT: state←LOCKED, bad_run←0, locked_o=1 next cycle.
  - data_i≠exp and data_i≠0: reseed; exp←nxt(data_i), good_run←1.
  - err_o and err_cnt_o are never updated in UNLOCKED.
- LOCKED, valid_i high:
  - exp←nxt(exp) always. The prediction free-runs, so a single corrupted word costs exactly one error.
  - data_i==exp: bad_run←0.
  - data_i≠exp: err_o=1 next cycle, err_cnt_o←err_cnt_o+1, saturating at 2^CNT_W−1. bad_run←bad_run+1.
  - If bad_run+1==UNLOCK_COUNT: state←UNLOCKED, good_run←0, exp←0, locked_o=0 next cycle. The unlocking word itself is counted as an error.
- clear_i: err_cnt_o←0 next cycle and takes priority over a simultaneous increment. err_o still pulses for that error. Lock state is unaffected.
- Latency: one cycle from the accepted word to locked_o, err_o or err_cnt_o reflecting it.
- Reset mid-operation aborts immediately to reset values; no error is counted for partial state.
- State machine: two states, UNLOCKED and LOCKED. Counters good_run and bad_run are sized ceil(log2(max(LOCK_COUNT, UNLOCK_COUNT)+1)) bits.

Test Plan:
- Lock acquisition: reset, then valid words 1,2,5,A on consecutive cycles → locked_o=1 the cycle after A; expected_o=4; err_cnt_o=0; err_o never high.
- Clean run: after lock, feed 12 correct words (4,8,1,2,5,A,…) with valid_i toggled randomly → err_cnt_o=0, locked_o stays 1, expected_o tracks the sequence.
- Single error: locked, send F in place of 4, then 8,1 → one err_o pulse; err_cnt_o=1; locked_o stays 1; no further errors.
- Loss and relock:
  - Locked, send 3 wrong words (0,0,0) → err_cnt_o=3 and locked_o=0 after the third.
  - Then 5,A,4,8 → locked_o=1 again; err_cnt_o holds 3.
- Seed edge cases: unlocked, zeros only → never locks, expected_o=0. Then 1,2,7,E,C → reseed at 7; the stream is inconsistent after 2, so no lock until 4 consistent words arrive.
- Clear, saturation and reset:
  - CNT_W=2 with 5 isolated errors → err_cnt_o saturates at 3.
  - clear_i together with an error → err_cnt_o=0 and err_o=1.
  - reset_n pulled low while locked → locked_o=0 and err_cnt_o=0 immediately, without waiting for a clock edge.
